// File: rtl/coin_tracker_if.sv
// Player/frame inputs and coin status outputs of the coin tracker.
// The master side drives the player and frame controls.
interface coin_tracker_if;
    logic       frame_clk;
    logic       new_game;
    logic       level_done;
    logic [9:0] Player_X;
    logic [9:0] Player_Y;
    logic [2:0] CoinStatus;
    logic [1:0] Coin_Count;
    logic       Coin_Pickup;
    logic       Score_Valid;

    modport master (
        output frame_clk, new_game, level_done, Player_X, Player_Y,
        input  CoinStatus, Coin_Count, Coin_Pickup, Score_Valid
    );

    modport slave (
        input  frame_clk, new_game, level_done, Player_X, Player_Y,
        output CoinStatus, Coin_Count, Coin_Pickup, Score_Valid
    );
endinterface

// File: rtl/coin_tracker.sv
// Per-frame coin collision tracker with level freeze on completion.
// Define COIN_MAGNET_EN to grow every coin hitbox by Magnet_Margin per side.
module coin_tracker #(
    parameter logic [9:0] Coin1_X   = 10'd120,
    parameter logic [9:0] Coin1_Y   = 10'd300,
    parameter logic [9:0] Coin2_X   = 10'd320,
    parameter logic [9:0] Coin2_Y   = 10'd260,
    parameter logic [9:0] Coin3_X   = 10'd520,
    parameter logic [9:0] Coin3_Y   = 10'd300,
    parameter logic [9:0] Coin_Size = 10'd16,
    parameter logic [9:0] Player_W  = 10'd16,
`ifdef COIN_MAGNET_EN
    parameter logic [9:0] Player_H  = 10'd32,
    parameter logic [9:0] Magnet_Margin = 10'd8
`else
    parameter logic [9:0] Player_H  = 10'd32
`endif
) (
    input  logic           Clk,
    input  logic           Reset,
    coin_tracker_if.slave  bus
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PLAYING  = 2'd1;
    localparam logic [1:0] FINISHED = 2'd2;

    logic [1:0] state;
    logic       frame_d;
    logic       frame_rise;
    logic [2:0] status;
    logic [1:0] count;
    logic       pickup;
    logic [2:0] hit_mask;
    logic [1:0] hit_cnt;

    // 11-bit compares so boxes near 1023 never wrap
    function automatic logic touch(
        input logic [9:0] cx,
        input logic [9:0] cy,
        input logic [9:0] px,
        input logic [9:0] py
    );
        logic [10:0] bx;
        logic [10:0] by;
        logic [10:0] sz;
`ifdef COIN_MAGNET_EN
        bx = (cx >= Magnet_Margin) ? {1'b0, cx} - {1'b0, Magnet_Margin} : 11'd0;
        by = (cy >= Magnet_Margin) ? {1'b0, cy} - {1'b0, Magnet_Margin} : 11'd0;
        sz = {1'b0, Coin_Size} + {Magnet_Margin, 1'b0};
`else
        bx = {1'b0, cx};
        by = {1'b0, cy};
        sz = {1'b0, Coin_Size};
`endif
        return ({1'b0, px} < bx + sz)
            && (bx < {1'b0, px} + {1'b0, Player_W})
            && ({1'b0, py} < by + sz)
            && (by < {1'b0, py} + {1'b0, Player_H});
    endfunction

    assign frame_rise = bus.frame_clk & ~frame_d;

    always_comb begin
        hit_mask    = 3'b000;
        hit_mask[0] = touch(Coin1_X, Coin1_Y, bus.Player_X, bus.Player_Y);
        hit_mask[1] = touch(Coin2_X, Coin2_Y, bus.Player_X, bus.Player_Y);
        hit_mask[2] = touch(Coin3_X, Coin3_Y, bus.Player_X, bus.Player_Y);
        hit_mask    = hit_mask & status;
        hit_cnt     = {1'b0, hit_mask[0]} + {1'b0, hit_mask[1]}
                    + {1'b0, hit_mask[2]};
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            frame_d <= 1'b0;
            status  <= 3'b111;
            count   <= 2'd0;
            pickup  <= 1'b0;
        end else begin
            frame_d <= bus.frame_clk;
            pickup  <= 1'b0;
            if (bus.new_game) begin
                state  <= PLAYING;
                status <= 3'b111;
                count  <= 2'd0;
            end else begin
                unique case (state)
                    PLAYING: begin
                        if (bus.level_done) begin
                            state <= FINISHED;
                        end else if (frame_rise) begin
                            status <= status & ~hit_mask;
                            count  <= count + hit_cnt;
                            pickup <= |hit_mask;
                        end
                    end
                    FINISHED: state <= FINISHED;
                    default:  state <= IDLE;
                endcase
            end
        end
    end

    assign bus.CoinStatus  = status;
    assign bus.Coin_Count  = count;
    assign bus.Coin_Pickup = pickup;
    assign bus.Score_Valid = (state == FINISHED);

endmodule

// File: tb/tb_coin_tracker.sv
// Scoreboard bench for coin_tracker: pickups are checked by monitors,
// steady state by direct checks between frames.
module tb_coin_tracker;
    logic Clk = 1'b0;
    logic Reset;
    int checks = 0;
    int errors = 0;
    logic [4:0] q0[$];
    logic [4:0] q1[$];

    always #10 Clk = ~Clk;

    coin_tracker_if if0 ();
    coin_tracker_if if1 ();

    coin_tracker dut (.Clk(Clk), .Reset(Reset), .bus(if0));

    coin_tracker #(
        .Coin2_X(10'd200), .Coin2_Y(10'd200),
        .Coin3_X(10'd208), .Coin3_Y(10'd216)
    ) dut2 (.Clk(Clk), .Reset(Reset), .bus(if1));

    always @(negedge Clk) begin
        if (Reset && if0.Coin_Pickup) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL pickup0 unexpected status=%b count=%0d",
                         if0.CoinStatus, if0.Coin_Count);
            end else begin
                logic [4:0] e;
                e = q0.pop_front();
                if ({if0.CoinStatus, if0.Coin_Count} != e) begin
                    errors++;
                    $display("FAIL pickup0 got %b/%0d want %b/%0d",
                             if0.CoinStatus, if0.Coin_Count, e[4:2], e[1:0]);
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (Reset && if1.Coin_Pickup) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL pickup1 unexpected status=%b count=%0d",
                         if1.CoinStatus, if1.Coin_Count);
            end else begin
                logic [4:0] e;
                e = q1.pop_front();
                if ({if1.CoinStatus, if1.Coin_Count} != e) begin
                    errors++;
                    $display("FAIL pickup1 got %b/%0d want %b/%0d",
                             if1.CoinStatus, if1.Coin_Count, e[4:2], e[1:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [2:0] st,
                       input logic [1:0] cn, input logic sv);
        @(negedge Clk);
        checks++;
        if (if0.CoinStatus !== st || if0.Coin_Count !== cn ||
            if0.Score_Valid !== sv || if0.Coin_Pickup !== 1'b0) begin
            errors++;
            $display("FAIL %s got %b/%0d/%b/%b want %b/%0d/%b/0", nm,
                     if0.CoinStatus, if0.Coin_Count, if0.Score_Valid,
                     if0.Coin_Pickup, st, cn, sv);
        end
    endtask

    task automatic new_game();
        @(posedge Clk); #1;
        if0.new_game = 1'b1;
        @(posedge Clk); #1;
        if0.new_game = 1'b0;
    endtask

    task automatic frame(input logic [9:0] px, input logic [9:0] py,
                         input logic ld);
        @(posedge Clk); #1;
        if0.Player_X   = px;
        if0.Player_Y   = py;
        if0.frame_clk  = 1'b1;
        if0.level_done = ld;
        @(posedge Clk); #1;
        if0.frame_clk  = 1'b0;
        if0.level_done = 1'b0;
        @(posedge Clk); #1;
    endtask

    initial begin
        Reset = 1'b0;
        if0.frame_clk = 0; if0.new_game = 0; if0.level_done = 0;
        if0.Player_X = 10'd0; if0.Player_Y = 10'd0;
        if1.frame_clk = 0; if1.new_game = 0; if1.level_done = 0;
        if1.Player_X = 10'd0; if1.Player_Y = 10'd0;
        repeat (3) @(posedge Clk);
        chk("reset", 3'b111, 2'd0, 1'b0);
        @(posedge Clk); #1;
        Reset = 1'b1;

        frame(10'd118, 10'd290, 1'b0);
        chk("idle_nohit", 3'b111, 2'd0, 1'b0);

        new_game();
        q0.push_back({3'b110, 2'd1});
        frame(10'd118, 10'd290, 1'b0);
        chk("coin1", 3'b110, 2'd1, 1'b0);
        frame(10'd118, 10'd290, 1'b0);
        chk("coin1_again", 3'b110, 2'd1, 1'b0);

`ifndef COIN_MAGNET_EN
        new_game();
        frame(10'd104, 10'd300, 1'b0);
        chk("touch_edge", 3'b111, 2'd0, 1'b0);
        q0.push_back({3'b110, 2'd1});
        frame(10'd105, 10'd300, 1'b0);
        chk("overlap1px", 3'b110, 2'd1, 1'b0);
`endif

        new_game();
`ifdef COIN_MAGNET_EN
        q0.push_back({3'b110, 2'd1});
        frame(10'd100, 10'd300, 1'b0);
        chk("magnet", 3'b110, 2'd1, 1'b0);
`else
        frame(10'd100, 10'd300, 1'b0);
        chk("no_magnet", 3'b111, 2'd0, 1'b0);
`endif

        // two coins in one frame on the second instance
        @(posedge Clk); #1;
        if1.new_game = 1'b1;
        @(posedge Clk); #1;
        if1.new_game  = 1'b0;
        if1.Player_X  = 10'd200;
        if1.Player_Y  = 10'd200;
        if1.frame_clk = 1'b1;
        q1.push_back({3'b001, 2'd2});
        @(posedge Clk); #1;
        if1.frame_clk = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (if1.CoinStatus !== 3'b001 || if1.Coin_Count !== 2'd2) begin
            errors++;
            $display("FAIL multi got %b/%0d want 001/2",
                     if1.CoinStatus, if1.Coin_Count);
        end

        new_game();
        q0.push_back({3'b110, 2'd1});
        frame(10'd118, 10'd290, 1'b0);
        frame(10'd520, 10'd300, 1'b1);
        chk("done_wins", 3'b110, 2'd1, 1'b1);
        frame(10'd520, 10'd300, 1'b0);
        chk("frozen", 3'b110, 2'd1, 1'b1);
        frame(10'd520, 10'd300, 1'b1);
        chk("done_in_fin", 3'b110, 2'd1, 1'b1);
        new_game();
        chk("restart", 3'b111, 2'd0, 1'b0);

        @(posedge Clk); #1;
        if0.new_game = 1'b1;
        if0.level_done = 1'b1;
        @(posedge Clk); #1;
        if0.new_game = 1'b0;
        if0.level_done = 1'b0;
        chk("ng_beats_ld", 3'b111, 2'd0, 1'b0);
        q0.push_back({3'b011, 2'd1});
        frame(10'd520, 10'd300, 1'b0);
        chk("coin3", 3'b011, 2'd1, 1'b0);

        @(posedge Clk); #1;
        if0.Player_X  = 10'd118;
        if0.Player_Y  = 10'd290;
        if0.new_game  = 1'b1;
        if0.frame_clk = 1'b1;
        @(posedge Clk); #1;
        if0.new_game  = 1'b0;
        if0.frame_clk = 1'b0;
        chk("ng_ignores_frame", 3'b111, 2'd0, 1'b0);

        q0.push_back({3'b110, 2'd1});
        @(posedge Clk); #1;
        if0.frame_clk = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        if0.Player_X = 10'd520;
        if0.Player_Y = 10'd300;
        repeat (3) @(posedge Clk);
        #1;
        if0.frame_clk = 1'b0;
        chk("level_held", 3'b110, 2'd1, 1'b0);

        @(posedge Clk); #3;
        Reset = 1'b0;
        #2;
        checks++;
        if (if0.CoinStatus !== 3'b111 || if0.Coin_Count !== 2'd0) begin
            errors++;
            $display("FAIL async_reset got %b/%0d want 111/0",
                     if0.CoinStatus, if0.Coin_Count);
        end
        @(posedge Clk); #1;
        Reset = 1'b1;
        frame(10'd118, 10'd290, 1'b0);
        chk("idle_after_rst", 3'b111, 2'd0, 1'b0);

        repeat (2) @(posedge Clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL missing_pickups left %0d/%0d want 0/0",
                     q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
